write_back_stage: RTL and testbench
===================================

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: Clk in 1 (rising edge); Reset in 1 (async assert, active-low).
REQ-002 SHALL have these pipeline-control inputs: Stall in 1, hold WB register; Flush in 1, insert bubble.
REQ-003 SHALL have these MEM-stage data inputs: ALUResultIn in 32; MemReadDataIn in 32; RtValueIn in 32, conditional-move test value; HiLoSrcIn in 32, mthi/mtlo source; MulResultIn in 64, {hi,lo} product; AddrLowIn in 2, byte lane.
REQ-004 SHALL have these MEM-stage control inputs, 1 bit each: WriteRegisterIn (5 bits), RegWriteIn, MemToRegIn, LbIn, LoadExtendedIn, HiWriteIn, LoWriteIn, MaddIn, MsubIn, HiOrLoIn, HiToRegIn, DontMoveIn, MoveOnNotZeroIn.
REQ-005 SHALL have these outputs to the decode register-file port: WriteRegister out 5; WriteData out 32; RegWrite out 1; Move out 1.
REQ-006 SHALL have these status outputs: Hi out 32; Lo out 32; Valid out 1; RetireCount out 32.

Function
REQ-007 SHALL capture all *In signals into the WB register on the rising edge when Stall=0; Valid<=1 on that edge.
REQ-008 SHALL, when Flush=1 at an edge, clear Valid and all control fields (bubble); Flush overrides Stall.
REQ-009 SHALL, when Stall=1 and Flush=0, hold the WB register and Valid unchanged.
REQ-010 SHALL drive WriteRegister, WriteData, RegWrite and Move combinationally from the WB register; latency MEM->register-file port is 1 cycle.
REQ-011 SHALL gate RegWrite: RegWrite = Valid & registered RegWriteIn.
REQ-012 SHALL compute Move as follows: Move = DontMove | (MoveOnNotZero ? RtValue!=0 : RtValue==0).
REQ-013 SHALL select WriteData by priority: HiToReg -> (HiOrLo ? Hi : Lo); else MemToReg & Lb -> byte; else MemToReg -> MemReadData; else ALUResult.
REQ-014 SHALL extract the load byte from MemReadData[8*AddrLow+7 : 8*AddrLow] (little-endian lanes); LoadExtended=1 sign-extends to 32 bits, 0 zero-extends.
REQ-015 SHALL commit HI/LO only on the edge where the bundle retires (Valid=1, Stall=0, Flush=0); it SHALL never commit twice during a stall.
REQ-016 SHALL apply these HI/LO commit rules:
  - HiWrite&LoWrite&Madd -> {Hi,Lo} += MulResult (64-bit, wrap mod 2^64)
  - HiWrite&LoWrite&Msub -> {Hi,Lo} -= MulResult (wrap)
  - HiWrite&LoWrite, neither Madd nor Msub -> {Hi,Lo} = MulResult
  - HiWrite only -> Hi = HiLoSrc
  - LoWrite only -> Lo = HiLoSrc
  - Madd&Msub both set -> treated as Madd
REQ-017 SHALL give mfhi/mflo in WB the committed value: an instruction retiring at edge N is visible to the instruction in WB after edge N.
REQ-018 SHALL increment RetireCount by 1 on each retire edge (REQ-015 condition); it wraps from 0xFFFFFFFF to 0.

Reset
REQ-019 SHALL, while Reset=0, asynchronously force Valid=0, all WB register fields=0, Hi=Lo=0 and RetireCount=0; RegWrite is therefore 0 and WriteData=0.
REQ-020 SHALL, on a reset mid-operation, discard any in-flight madd/msub with no partial HI/LO update; the first capture edge after release behaves as REQ-007.

Structure
REQ-021 SHALL place the WB bundle field widths and the WriteData select encoding in the shared pipeline package; no new typedefs are local to this module.
REQ-022 SHALL implement the HI/LO pair plus accumulate logic as one sub-module, HiLoRegister; the remaining logic (WB register, muxes, counter) stays in write_back_stage.

Verification
REQ-023 SHALL cover the ALU writeback: ALUResultIn=0x1234, WriteRegisterIn=5, RegWriteIn=1, Stall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234, RetireCount=1.
REQ-024 SHALL cover byte loads: MemReadDataIn=0x80FF7F01, AddrLowIn=3, Lb=1 -> LoadExtended=1 gives 0xFFFFFF80; LoadExtended=0 gives 0x00000080.
REQ-025 SHALL cover accumulate across a stall: Hi=0, Lo=0xFFFFFFFF, then madd with MulResult=1 while Stall=1 for 3 cycles -> Hi:Lo=1:0x00000000 exactly once after release; a following mfhi writes 1.
REQ-026 SHALL cover conditional moves: movz with RtValue=0 -> Move=1; movn with RtValue=0 -> Move=0; DontMove=1 -> Move=1 regardless.
REQ-027 SHALL cover Flush priority: Flush=1 and Stall=1 on the same edge -> Valid=0, RegWrite=0, no HI/LO change, RetireCount unchanged.
REQ-028 SHALL cover async reset: Reset asserted between edges during a pending msub -> Hi=Lo=0, Valid=0 immediately, with no update at the next edge.

Source files
------------

// File: rtl/write_back_stage_pkg.sv
// Shared pipeline definitions for the write-back stage: bundle layout and
// WriteData source selection.
package write_back_stage_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned LaneW    = 2;
  localparam int unsigned MulW     = 64;

  typedef enum logic [1:0] {
    WdAlu  = 2'd0,
    WdMem  = 2'd1,
    WdByte = 2'd2,
    WdHiLo = 2'd3
  } wd_sel_e;

  typedef struct packed {
    logic [DataW-1:0]    alu_result;
    logic [DataW-1:0]    mem_read_data;
    logic [DataW-1:0]    rt_value;
    logic [DataW-1:0]    hi_lo_src;
    logic [MulW-1:0]     mul_result;
    logic [LaneW-1:0]    addr_low;
    logic [RegAddrW-1:0] write_register;
    logic                reg_write;
    logic                mem_to_reg;
    logic                lb;
    logic                load_extended;
    logic                hi_write;
    logic                lo_write;
    logic                madd;
    logic                msub;
    logic                hi_or_lo;
    logic                hi_to_reg;
    logic                dont_move;
    logic                move_on_not_zero;
  } wb_bundle_t;

  // HI/LO reads win over loads; byte loads win over word loads.
  function automatic wd_sel_e wd_select(input logic hi_to_reg, input logic mem_to_reg,
                                        input logic lb);
    if (hi_to_reg) begin
      return WdHiLo;
    end else if (mem_to_reg && lb) begin
      return WdByte;
    end else if (mem_to_reg) begin
      return WdMem;
    end
    return WdAlu;
  endfunction

endpackage

// File: rtl/write_back_stage_hilo.sv
// HI/LO register pair with multiply-accumulate commit, updated only when the
// owning instruction retires.
module HiLoRegister
  import write_back_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic             madd,
  input  logic             msub,
  input  logic [MulW-1:0]  mul_result,
  input  logic [DataW-1:0] hi_lo_src,
  output logic [DataW-1:0] hi,
  output logic [DataW-1:0] lo
);

  logic [MulW-1:0] hilo_q, hilo_d;

  always_comb begin
    hilo_d = hilo_q;
    if (commit) begin
      if (hi_write && lo_write) begin
        // madd takes precedence when both accumulate flags are set
        if (madd) begin
          hilo_d = hilo_q + mul_result;
        end else if (msub) begin
          hilo_d = hilo_q - mul_result;
        end else begin
          hilo_d = mul_result;
        end
      end else if (hi_write) begin
        hilo_d = {hi_lo_src, hilo_q[DataW-1:0]};
      end else if (lo_write) begin
        hilo_d = {hilo_q[MulW-1:DataW], hi_lo_src};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  assign hi = hilo_q[MulW-1:DataW];
  assign lo = hilo_q[DataW-1:0];

endmodule

// File: rtl/write_back_stage.sv
// Write-back pipeline stage: WB register, write-data/move selection, HI/LO
// commit and retire counter.
module write_back_stage
  import write_back_stage_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [DataW-1:0]    ALUResultIn,
  input  logic [DataW-1:0]    MemReadDataIn,
  input  logic [DataW-1:0]    RtValueIn,
  input  logic [DataW-1:0]    HiLoSrcIn,
  input  logic [MulW-1:0]     MulResultIn,
  input  logic [LaneW-1:0]    AddrLowIn,
  input  logic [RegAddrW-1:0] WriteRegisterIn,
  input  logic                RegWriteIn,
  input  logic                MemToRegIn,
  input  logic                LbIn,
  input  logic                LoadExtendedIn,
  input  logic                HiWriteIn,
  input  logic                LoWriteIn,
  input  logic                MaddIn,
  input  logic                MsubIn,
  input  logic                HiOrLoIn,
  input  logic                HiToRegIn,
  input  logic                DontMoveIn,
  input  logic                MoveOnNotZeroIn,
  output logic [RegAddrW-1:0] WriteRegister,
  output logic [DataW-1:0]    WriteData,
  output logic                RegWrite,
  output logic                Move,
  output logic [DataW-1:0]    Hi,
  output logic [DataW-1:0]    Lo,
  output logic                Valid,
  output logic [DataW-1:0]    RetireCount
);

  wb_bundle_t       bundle_in, wb_q;
  logic             valid_q;
  logic [DataW-1:0] retire_cnt_q;
  logic             retire;
  logic [7:0]       load_byte;
  logic [DataW-1:0] byte_data;

  always_comb begin
    bundle_in                  = '0;
    bundle_in.alu_result       = ALUResultIn;
    bundle_in.mem_read_data    = MemReadDataIn;
    bundle_in.rt_value         = RtValueIn;
    bundle_in.hi_lo_src        = HiLoSrcIn;
    bundle_in.mul_result       = MulResultIn;
    bundle_in.addr_low         = AddrLowIn;
    bundle_in.write_register   = WriteRegisterIn;
    bundle_in.reg_write        = RegWriteIn;
    bundle_in.mem_to_reg       = MemToRegIn;
    bundle_in.lb               = LbIn;
    bundle_in.load_extended    = LoadExtendedIn;
    bundle_in.hi_write         = HiWriteIn;
    bundle_in.lo_write         = LoWriteIn;
    bundle_in.madd             = MaddIn;
    bundle_in.msub             = MsubIn;
    bundle_in.hi_or_lo         = HiOrLoIn;
    bundle_in.hi_to_reg        = HiToRegIn;
    bundle_in.dont_move        = DontMoveIn;
    bundle_in.move_on_not_zero = MoveOnNotZeroIn;
  end

  // The bundle in WB leaves the stage on this edge.
  assign retire = valid_q & ~Stall & ~Flush;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wb_q         <= '0;
      valid_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (Flush) begin
        wb_q    <= '0;
        valid_q <= 1'b0;
      end else if (!Stall) begin
        wb_q    <= bundle_in;
        valid_q <= 1'b1;
      end
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
      end
    end
  end

  HiLoRegister u_hilo (
    .clk        (Clk),
    .rst_n      (Reset),
    .commit     (retire),
    .hi_write   (wb_q.hi_write),
    .lo_write   (wb_q.lo_write),
    .madd       (wb_q.madd),
    .msub       (wb_q.msub),
    .mul_result (wb_q.mul_result),
    .hi_lo_src  (wb_q.hi_lo_src),
    .hi         (Hi),
    .lo         (Lo)
  );

  always_comb begin
    load_byte = 8'h00;
    unique case (wb_q.addr_low)
      2'd0: load_byte = wb_q.mem_read_data[7:0];
      2'd1: load_byte = wb_q.mem_read_data[15:8];
      2'd2: load_byte = wb_q.mem_read_data[23:16];
      2'd3: load_byte = wb_q.mem_read_data[31:24];
      default: load_byte = 8'h00;
    endcase
    byte_data = {{(DataW-8){wb_q.load_extended & load_byte[7]}}, load_byte};
  end

  always_comb begin
    WriteData = wb_q.alu_result;
    unique case (wd_select(wb_q.hi_to_reg, wb_q.mem_to_reg, wb_q.lb))
      WdHiLo:  WriteData = wb_q.hi_or_lo ? Hi : Lo;
      WdByte:  WriteData = byte_data;
      WdMem:   WriteData = wb_q.mem_read_data;
      WdAlu:   WriteData = wb_q.alu_result;
      default: WriteData = wb_q.alu_result;
    endcase
  end

  assign WriteRegister = wb_q.write_register;
  assign RegWrite      = valid_q & wb_q.reg_write;
  assign Move          = wb_q.dont_move |
                         (wb_q.move_on_not_zero ? (wb_q.rt_value != '0) : (wb_q.rt_value == '0));
  assign Valid         = valid_q;
  assign RetireCount   = retire_cnt_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios plus randomized
// instruction/stall/flush traffic against a behavioural reference model.
module tb_write_back_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] rt;
    logic [31:0] src;
    logic [63:0] mul;
    logic [1:0]  addr;
    logic [4:0]  wr;
    logic rw, m2r, lb, ext, hw, lw, madd, msub, hol, h2r, dm, mnz;
  } instr_t;

  logic        Clk, Reset, Stall, Flush;
  instr_t      cur;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, Hi, Lo, RetireCount;
  logic        RegWrite, Move, Valid;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  instr_t      m_wb;
  logic [63:0] m_acc;
  logic [31:0] m_cnt;

  write_back_stage dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Flush           (Flush),
    .ALUResultIn     (cur.alu),
    .MemReadDataIn   (cur.mem),
    .RtValueIn       (cur.rt),
    .HiLoSrcIn       (cur.src),
    .MulResultIn     (cur.mul),
    .AddrLowIn       (cur.addr),
    .WriteRegisterIn (cur.wr),
    .RegWriteIn      (cur.rw),
    .MemToRegIn      (cur.m2r),
    .LbIn            (cur.lb),
    .LoadExtendedIn  (cur.ext),
    .HiWriteIn       (cur.hw),
    .LoWriteIn       (cur.lw),
    .MaddIn          (cur.madd),
    .MsubIn          (cur.msub),
    .HiOrLoIn        (cur.hol),
    .HiToRegIn       (cur.h2r),
    .DontMoveIn      (cur.dm),
    .MoveOnNotZeroIn (cur.mnz),
    .WriteRegister   (WriteRegister),
    .WriteData       (WriteData),
    .RegWrite        (RegWrite),
    .Move            (Move),
    .Hi              (Hi),
    .Lo              (Lo),
    .Valid           (Valid),
    .RetireCount     (RetireCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input instr_t i, input logic [63:0] acc);
    int unsigned b;
    if (i.h2r) return i.hol ? acc[63:32] : acc[31:0];
    if (i.m2r && i.lb) begin
      b = (i.mem / (32'd1 << (8 * i.addr))) % 256;
      if (i.ext && b >= 128) return 32'hFFFF_FF00 + b;
      return b;
    end
    if (i.m2r) return i.mem;
    return i.alu;
  endfunction

  function automatic logic exp_move(input instr_t i);
    if (i.dm) return 1'b1;
    if (i.mnz) return i.rt != 0;
    return i.rt == 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_wb    = '0;
    m_acc   = 64'd0;
    m_cnt   = 32'd0;
  endtask

  task automatic model_edge();
    if (Flush) begin
      m_valid = 1'b0;
      m_wb    = '0;
    end else if (!Stall) begin
      if (m_valid) begin
        m_cnt++;
        if (m_wb.hw && m_wb.lw) begin
          if (m_wb.madd)      m_acc = m_acc + m_wb.mul;
          else if (m_wb.msub) m_acc = m_acc - m_wb.mul;
          else                m_acc = m_wb.mul;
        end else if (m_wb.hw) begin
          m_acc[63:32] = m_wb.src;
        end else if (m_wb.lw) begin
          m_acc[31:0] = m_wb.src;
        end
      end
      m_wb    = cur;
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", Valid, m_valid);
    chk("regwrite", RegWrite, m_valid & m_wb.rw);
    if (m_valid) begin
      chk("wreg", WriteRegister, m_wb.wr);
      chk("wdata", WriteData, exp_wd(m_wb, m_acc));
      chk("move", Move, exp_move(m_wb));
    end
    chk("hi", Hi, m_acc[63:32]);
    chk("lo", Lo, m_acc[31:0]);
    chk("retire_count", RetireCount, m_cnt);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_edge();
    #1;
    check_all();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.alu  = $urandom;
    i.mem  = $urandom;
    i.rt   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    i.src  = $urandom;
    i.mul  = {$urandom, $urandom};
    i.addr = 2'($urandom_range(0, 3));
    i.wr   = 5'($urandom_range(0, 31));
    i.rw   = 1'($urandom_range(0, 1));
    i.m2r  = 1'($urandom_range(0, 1));
    i.lb   = 1'($urandom_range(0, 1));
    i.ext  = 1'($urandom_range(0, 1));
    i.hw   = 1'($urandom_range(0, 1));
    i.lw   = 1'($urandom_range(0, 1));
    i.madd = 1'($urandom_range(0, 1));
    i.msub = 1'($urandom_range(0, 1));
    i.hol  = 1'($urandom_range(0, 1));
    i.h2r  = ($urandom_range(0, 3) == 0);
    i.dm   = 1'($urandom_range(0, 1));
    i.mnz  = 1'($urandom_range(0, 1));
    return i;
  endfunction

  logic [31:0] save_hi, save_lo, save_cnt;

  initial begin
    Reset = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    cur   = '0;
    model_reset();
    #12;
    chk("rst_valid", Valid, 1'b0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    chk("rst_count", RetireCount, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // ALU writeback, preceded by one bubble-free nop so it counts as the first retire
    cur = '0;
    tick();
    cur = '0; cur.alu = 32'h1234; cur.wr = 5'd5; cur.rw = 1'b1;
    tick();
    chk("alu_regwrite", RegWrite, 1'b1);
    chk("alu_wreg", WriteRegister, 5'd5);
    chk("alu_wdata", WriteData, 32'h1234);
    chk("alu_count", RetireCount, 32'd1);

    // Byte loads, lane 3
    cur = '0; cur.mem = 32'h80FF_7F01; cur.addr = 2'd3; cur.m2r = 1'b1; cur.lb = 1'b1;
    cur.rw = 1'b1; cur.ext = 1'b1;
    tick();
    chk("lb_sext", WriteData, 32'hFFFF_FF80);
    cur.ext = 1'b0;
    tick();
    chk("lb_zext", WriteData, 32'h0000_0080);

    // madd held over a 3-cycle stall commits exactly once
    cur = '0; cur.lw = 1'b1; cur.src = 32'hFFFF_FFFF;
    tick();
    cur = '0; cur.hw = 1'b1; cur.lw = 1'b1; cur.madd = 1'b1; cur.mul = 64'd1;
    tick();
    chk("pre_madd_hilo", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("stall_hilo", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    Stall = 1'b0;
    cur = '0; cur.h2r = 1'b1; cur.hol = 1'b1; cur.rw = 1'b1; cur.wr = 5'd2;
    tick();
    chk("madd_hilo", {Hi, Lo}, 64'h0000_0001_0000_0000);
    chk("mfhi_wdata", WriteData, 32'd1);
    cur = '0;
    tick();
    chk("madd_once", {Hi, Lo}, 64'h0000_0001_0000_0000);

    // Conditional moves
    cur = '0; cur.rt = 32'd0;
    tick();
    chk("movz_zero", Move, 1'b1);
    cur.mnz = 1'b1;
    tick();
    chk("movn_zero", Move, 1'b0);
    cur.dm = 1'b1;
    tick();
    chk("dont_move", Move, 1'b1);

    // Flush beats stall
    cur = '0; cur.hw = 1'b1; cur.src = 32'hDEAD_BEEF; cur.rw = 1'b1;
    tick();
    save_hi = Hi; save_lo = Lo; save_cnt = RetireCount;
    Flush = 1'b1; Stall = 1'b1;
    tick();
    chk("flush_valid", Valid, 1'b0);
    chk("flush_regwrite", RegWrite, 1'b0);
    chk("flush_hilo", {Hi, Lo}, {save_hi, save_lo});
    chk("flush_count", RetireCount, save_cnt);
    Flush = 1'b0; Stall = 1'b0;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      cur   = rand_instr();
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    Stall = 1'b0; Flush = 1'b0;

    // Async reset between edges during a pending msub
    cur = '0; cur.hw = 1'b1; cur.lw = 1'b1; cur.src = 32'h55; cur.mul = 64'h1234_5678_9ABC_DEF0;
    tick();
    cur.hw = 1'b1; cur.lw = 1'b1; cur.msub = 1'b1; cur.mul = 64'd7;
    tick();
    chk("pre_rst_valid", Valid, 1'b1);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("async_hilo", {Hi, Lo}, 64'd0);
    chk("async_valid", Valid, 1'b0);
    tick();
    chk("rst_edge_hilo", {Hi, Lo}, 64'd0);
    chk("rst_edge_count", RetireCount, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    cur = '0; cur.rw = 1'b1; cur.alu = 32'hA5A5_0001; cur.wr = 5'd9;
    tick();
    chk("post_rst_wdata", WriteData, 32'hA5A5_0001);
    chk("post_rst_count", RetireCount, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
